// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
//   Serial pattern transmitter. Sends PATTERN (PAT_W bits, MSB first) rep_cnt
//   times. GAP_BITS zero bits are inserted between repetitions. Each bit
//   advances on a clk edge where bit_en=1. The serial output drives the
//   input of the team's serial sequence detectors.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   start    in   1      transmit request, only looked at in IDLE
//   rep_cnt  in   CNT_W  repetition count, latched when start is accepted
//   bit_en   in   1      bit strobe
//   abort    in   1      synchronous abort; forces IDLE from any state
//   a_out    out  1      serial data bit (registered)
//   a_valid  out  1      high for one cycle per emitted bit (registered)
//   busy     out  1      high in SEND/GAP
//   done     out  1      single-cycle pulse on normal completion
module seq_pattern_gen #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1010,
  parameter int               CNT_W    = 8,
  parameter int               GAP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             bit_en,
  input  logic             abort,
  output logic             a_out,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GCW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] shreg;
  logic [BIW-1:0]   bit_idx;
  logic [CNT_W-1:0] reps_left;
  logic [GCW-1:0]   gap_cnt;

  // busy and done are pure decodes of the state register (Moore outputs).
  assign busy = (state == SEND) || (state == GAP);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      reps_left <= '0;
      gap_cnt   <= '0;
      a_out     <= 1'b0;
      a_valid   <= 1'b0;
    end else if (abort) begin
      // Abort takes priority over start and over last-bit completion.
      state   <= IDLE;
      a_out   <= 1'b0;
      a_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_out   <= 1'b0;
          a_valid <= 1'b0;
          if (start) begin
            if (rep_cnt != '0) begin
              reps_left <= rep_cnt;
              shreg     <= PATTERN;
              bit_idx   <= BIW'(PAT_W - 1);
              state     <= SEND;
            end else begin
              // Zero repetitions: complete immediately without emitting bits.
              state <= DONE;
            end
          end
        end

        SEND: begin
          if (bit_en) begin
            a_out   <= shreg[PAT_W-1];
            a_valid <= 1'b1;
            if (bit_idx == '0) begin
              reps_left <= reps_left - 1'b1;
              if (reps_left == CNT_W'(1)) begin
                shreg <= shreg << 1;
                state <= DONE;
              end else if (GAP_BITS > 0) begin
                shreg   <= shreg << 1;
                gap_cnt <= GCW'(GAP_BITS);
                state   <= GAP;
              end else begin
                // Back-to-back repetitions: reload without leaving SEND.
                shreg   <= PATTERN;
                bit_idx <= BIW'(PAT_W - 1);
              end
            end else begin
              shreg   <= shreg << 1;
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            // Stalled strobe: a_out keeps the last bit, nothing advances.
            a_valid <= 1'b0;
          end
        end

        GAP: begin
          if (bit_en) begin
            a_out   <= 1'b0;
            a_valid <= 1'b1;
            if (gap_cnt == GCW'(1)) begin
              gap_cnt <= '0;
              shreg   <= PATTERN;
              bit_idx <= BIW'(PAT_W - 1);
              state   <= SEND;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end else begin
            a_valid <= 1'b0;
          end
        end

        DONE: begin
          // The final bit is visible in this cycle alongside done. Any start
          // request seen here is dropped rather than queued.
          a_out   <= 1'b0;
          a_valid <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          a_out   <= 1'b0;
          a_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen with default parameters (1010, CNT_W=8,
// GAP_BITS=1). A queue-based model holds the full expected bit stream of the
// accepted request. Every cycle, the DUT outputs are compared against that
// model on the falling edge. Directed sections pin the model with literal
// values.
module tb_seq_pattern_gen;
  logic       clk = 1'b0;
  logic       rst, start, bit_en, abort;
  logic [7:0] rep_cnt;
  logic       a_out, a_valid, busy, done;

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .rep_cnt(rep_cnt), .bit_en(bit_en),
    .abort(abort), .a_out(a_out), .a_valid(a_valid), .busy(busy), .done(done)
  );

  int cmp = 0;
  int mis = 0;

  // model state
  bit m_busy, m_done, m_valid, m_aout;
  bit q[$];
  bit chk_en = 1'b0;

  // detector on the loopback stream
  logic [3:0] dsh;
  int         dcnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    q.delete();
    m_busy = 0; m_done = 0; m_valid = 0; m_aout = 0;
  endtask

  // One clock edge of the behavioural model. Inputs are those present before the edge.
  task automatic model_step(input bit s, input logic [7:0] rc, input bit be, input bit ab);
    logic [3:0] pat;
    pat = 4'b1010;
    if (ab) begin
      model_zero();
    end else if (m_busy) begin
      if (be) begin
        m_aout  = q.pop_front();
        m_valid = 1;
        if (q.size() == 0) begin m_busy = 0; m_done = 1; end
      end else begin
        m_valid = 0;
      end
    end else if (m_done) begin
      m_done = 0; m_valid = 0; m_aout = 0;
    end else begin
      m_valid = 0; m_aout = 0;
      if (s) begin
        if (rc != 0) begin
          for (int r = 0; r < int'(rc); r++) begin
            for (int b = 3; b >= 0; b--) q.push_back(pat[b]);
            if (r < int'(rc) - 1) q.push_back(1'b0);
          end
          m_busy = 1;
        end else begin
          m_done = 1;
        end
      end
    end
  endtask

  task automatic tick();
    bit s, be, ab, rr;
    logic [7:0] rc;
    s = start; be = bit_en; ab = abort; rr = rst; rc = rep_cnt;
    @(posedge clk);
    if (rr) model_zero();
    else model_step(s, rc, be, ab);
    #1;
    if (a_valid === 1'b1) begin
      dsh = {dsh[2:0], a_out};
      if (dsh == 4'b1010) dcnt++;
    end
  endtask

  // Runs n cycles with bit_en high every per-th cycle. Collects emitted bits and done pulses.
  task automatic collect(input int n, input int per, output logic [31:0] bits,
                         output int nb, output int nd);
    bits = '0; nb = 0; nd = 0;
    for (int c = 0; c < n; c++) begin
      bit_en = (c % per) == 0;
      tick();
      if (a_valid === 1'b1) begin bits = {bits[30:0], a_out}; nb++; end
      if (done === 1'b1) nd++;
    end
    bit_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_valid", a_valid, m_valid);
      check("a_out",   a_out,   m_aout);
      check("busy",    busy,    m_busy);
      check("done",    done,    m_done);
    end
  end

  initial begin
    logic [31:0] bits;
    logic [3:0]  p1;
    int nb, nd, cnt;
    bit seen;
    p1 = 4'b1010;
    dsh = '0; dcnt = 0;
    rst = 1; start = 0; bit_en = 0; abort = 0; rep_cnt = 0;
    model_zero();
    repeat (3) tick();
    check("rst_a_out", a_out, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 0;
    tick();
    chk_en = 1;

    // T1: single repetition, exact latency
    bit_en = 1; rep_cnt = 1; start = 1;
    tick(); start = 0;
    check("t1_busy_T1", busy, 1);
    check("t1_valid_T1", a_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", a_valid, 1);
      check("t1_bit", a_out, p1[3-i]);
      check("t1_done", done, (i == 3));
      check("t1_busy", busy, (i < 3));
    end
    tick();
    check("t1_done_after", done, 0);
    check("t1_valid_after", a_valid, 0);

    // T2: three repetitions with gap bits
    rep_cnt = 3; start = 1; tick(); start = 0;
    collect(20, 1, bits, nb, nd);
    check("t2_bits", bits, 32'b10100101001010);
    check("t2_nbits", nb, 14);
    check("t2_ndone", nd, 1);

    // T3: bit_en every 3rd cycle
    rep_cnt = 2; start = 1; tick(); start = 0;
    collect(40, 3, bits, nb, nd);
    check("t3_bits", bits, 32'b101001010);
    check("t3_nbits", nb, 9);
    check("t3_ndone", nd, 1);

    // T4: zero repetitions
    rep_cnt = 0; start = 1; tick(); start = 0;
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_valid", a_valid, 0);
    tick();
    check("t4_done_after", done, 0);

    // T5: abort after two bits, then a fresh full pattern
    rep_cnt = 2; start = 1; tick(); start = 0;
    tick();
    check("t5_bit0", a_out, 1);
    tick();
    check("t5_bit1", a_out, 0);
    abort = 1; tick(); abort = 0;
    check("t5_busy", busy, 0);
    check("t5_valid", a_valid, 0);
    check("t5_done", done, 0);
    tick();
    check("t5_done2", done, 0);
    rep_cnt = 1; start = 1; tick(); start = 0;
    collect(6, 1, bits, nb, nd);
    check("t5_bits", bits, 32'b1010);
    check("t5_nbits", nb, 4);
    check("t5_ndone", nd, 1);

    // T6: loopback into a 1010 detector, then async reset mid-stream
    dsh = '0; dcnt = 0;
    rep_cnt = 5; start = 1; tick(); start = 0;
    collect(30, 1, bits, nb, nd);
    check("t6_detects", dcnt, 5);
    check("t6_ndone", nd, 1);
    rep_cnt = 5; start = 1; tick(); start = 0;
    collect(7, 1, bits, nb, nd);
    rst = 1; #1;
    model_zero();
    check("t6_rst_a_out", a_out, 0);
    check("t6_rst_valid", a_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    tick(); tick();
    rst = 0; tick();

    // max repetition count must finish without counter wrap
    rep_cnt = 8'hFF; start = 1; tick(); start = 0;
    cnt = 0; seen = 0;
    for (int c = 0; c < 1400 && !seen; c++) begin
      tick();
      if (a_valid === 1'b1) cnt++;
      if (done === 1'b1) seen = 1;
    end
    check("max_nbits", cnt, 1274);
    check("max_done_seen", seen, 1);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      rep_cnt = 8'($urandom_range(0, 5));
      bit_en  = ($urandom_range(0, 2) != 0);
      abort   = ($urandom_range(0, 63) == 0);
      tick();
    end
    start = 0; abort = 0; bit_en = 1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
